xspi_retry_ctrl: RTL and testbench

Transaction sequencer for the xSPI 8S CRC datapath. It accepts one host request at a time and issues it to the xSPI master core. It evaluates the CA and data CRC flags when the core reports completion, and retransmits the identical transaction on CRC error up to a bounded count. It then returns a single response carrying status, read data and retry count, sitting between the host/bus adapter and the master core.

---
 rtl/xspi_pkg.sv | 28 ++
 rtl/xspi_retry_timer.sv | 27 ++
 rtl/xspi_retry_ctrl.sv | 176 +++++++++++++++++
 tb/tb_xspi_retry_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xspi_pkg.sv
// Shared definitions for the xSPI 8S CRC datapath: widths, opcodes, status codes
// and sequencer states, reused by the retry controller, monitor and core.
package xspi_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ADDR_W  = 48;
    localparam int unsigned CMD_W   = 8;
    localparam int unsigned RETRY_W = 4;

    localparam logic [CMD_W-1:0] CMD_WRITE = 8'hA5;
    localparam logic [CMD_W-1:0] CMD_READ  = 8'hFF;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_CRC_FAIL = 2'b01,
        ST_TIMEOUT  = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_GAP,
        S_RESP
    } state_e;

endpackage

// File: rtl/xspi_retry_timer.sv
// Loadable down-counter shared by the per-attempt timeout and the retry gap.
// Load wins over counting; the count holds at zero, where o_expire stays high.
module xspi_retry_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/xspi_retry_ctrl.sv
// Single-outstanding transaction sequencer in front of the xSPI master core:
// issues a request, checks CRC flags on completion, retransmits on CRC error.
module xspi_retry_ctrl
    import xspi_pkg::*;
#(
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CMD_W-1:0]    req_cmd,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [RETRY_W-1:0]  rsp_retries,
    output logic                start,
    output logic [CMD_W-1:0]    command,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                done,
    input  logic                crc_ca_error_slave,
    input  logic                crc_data_error_slave,
    input  logic                crc_data_error_master,
    output logic                busy
);

    localparam int unsigned TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

    state_e               r_state;
    status_e              r_status;
    logic                 r_start;
    logic                 r_rsp_valid;
    logic                 r_busy;
    logic                 r_err;
    logic [RETRY_W-1:0]   r_attempt;
    logic [CMD_W-1:0]     r_cmd;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rd_cap;
    logic [DATA_W-1:0]    r_rsp_rdata;

    logic                 w_err;
    logic                 w_tmr_load;
    logic [TW-1:0]        w_tmr_val;
    logic                 w_tmr_expire;

    // Which data CRC flag matters depends on who checked the data phase.
    always_comb begin
        w_err = crc_ca_error_slave;
        case (r_cmd)
            CMD_WRITE: w_err = crc_ca_error_slave | crc_data_error_slave;
            CMD_READ:  w_err = crc_ca_error_slave | crc_data_error_master;
            default:   w_err = crc_ca_error_slave;
        endcase
    end

    // ISSUE arms the WAIT timeout; EVAL arms the gap (unused if no retry follows).
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TO_LOAD;
        if (r_state == S_ISSUE) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = TO_LOAD;
        end else if (r_state == S_EVAL) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = GAP_LOAD;
        end
    end

    xspi_retry_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_status    <= ST_OK;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_attempt   <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_cap    <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cmd     <= req_cmd;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_attempt <= '0;
                        r_busy    <= 1'b1;
                        r_start   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (done) begin
                        r_rd_cap <= rd_data;
                        r_err    <= w_err;
                        r_state  <= S_EVAL;
                    end else if (w_tmr_expire) begin
                        r_status    <= ST_TIMEOUT;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_EVAL: begin
                    if (!r_err) begin
                        r_status    <= ST_OK;
                        r_rsp_rdata <= (r_cmd == CMD_READ) ? r_rd_cap : '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_attempt < RETRY_W'(MAX_RETRY)) begin
                        r_attempt <= r_attempt + 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        r_status    <= ST_CRC_FAIL;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_GAP: begin
                    if (w_tmr_expire) begin
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign start       = r_start;
    assign busy        = r_busy;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_status  = r_status;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_retries = r_attempt;
    assign command     = r_cmd;
    assign address     = r_addr;
    assign wr_data     = r_wdata;

endmodule

// File: tb/tb_xspi_retry_ctrl.sv
// Self-checking bench for xspi_retry_ctrl: directed vector table, reset and
// backpressure sequences, then random transactions against a reference model.
module tb_xspi_retry_ctrl;

    localparam int MAX_RETRY  = 3;
    localparam int TIMEOUT    = 1024;
    localparam int GAP_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [47:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [63:0] rsp_rdata;
    logic [3:0]  rsp_retries;
    logic        start;
    logic [7:0]  command;
    logic [47:0] address;
    logic [63:0] wr_data;
    logic [63:0] rd_data;
    logic        done;
    logic        crc_ca_error_slave;
    logic        crc_data_error_slave;
    logic        crc_data_error_master;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    xspi_retry_ctrl #(
        .MAX_RETRY  (MAX_RETRY),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_cmd               (req_cmd),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_status            (rsp_status),
        .rsp_rdata             (rsp_rdata),
        .rsp_retries           (rsp_retries),
        .start                 (start),
        .command               (command),
        .address               (address),
        .wr_data               (wr_data),
        .rd_data               (rd_data),
        .done                  (done),
        .crc_ca_error_slave    (crc_ca_error_slave),
        .crc_data_error_slave  (crc_data_error_slave),
        .crc_data_error_master (crc_data_error_master),
        .busy                  (busy)
    );

    // flags: 3 bits per attempt {ca_slave, data_slave, data_master}, attempt i at [3i+:3]
    typedef struct {
        logic [7:0]  cmd;
        logic [47:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [11:0] flags;
        int          to_att;
        bit          spur;
        int          hold;
        logic [1:0]  st;
        logic [3:0]  ret;
        logic [63:0] rdo;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one request derived directly from the retry rules.
    function automatic void model(input logic [7:0] cmd, input logic [11:0] flags,
                                  input int to_att, input logic [63:0] rd,
                                  output logic [1:0] st, output logic [3:0] ret,
                                  output logic [63:0] rdo);
        logic [2:0] f;
        bit err;
        st = 2'b00; ret = 4'd0; rdo = 64'h0;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            f = flags[3*i +: 3];
            if (i == to_att) begin
                st = 2'b10; ret = 4'(i); rdo = 64'h0;
                return;
            end
            err = f[2] || (cmd == 8'hA5 && f[1]) || (cmd == 8'hFF && f[0]);
            if (!err) begin
                st = 2'b00; ret = 4'(i); rdo = (cmd == 8'hFF) ? rd : 64'h0;
                return;
            end
            if (i == MAX_RETRY) begin
                st = 2'b01; ret = 4'(i); rdo = 64'h0;
                return;
            end
        end
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"},     64'(start),       64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid),   64'(0));
        chk({tag, "_busy"},      64'(busy),        64'(0));
        chk({tag, "_status"},    64'(rsp_status),  64'(0));
        chk({tag, "_rdata"},     rsp_rdata,        64'(0));
        chk({tag, "_retries"},   64'(rsp_retries), 64'(0));
        chk({tag, "_command"},   64'(command),     64'(0));
        chk({tag, "_address"},   64'(address),     64'(0));
        chk({tag, "_wr_data"},   wr_data,          64'(0));
        chk({tag, "_req_ready"}, 64'(req_ready),   64'(1));
    endtask

    // Plays host and core for one request; core answers 0..5 cycles into WAIT.
    task automatic run_txn(input logic [7:0] cmd, input logic [47:0] addr,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input logic [11:0] flags, input int to_att,
                           input bit spur, input int hold,
                           input logic [1:0] e_st, input logic [3:0] e_ret,
                           input logic [63:0] e_rd);
        int t, att, s_last, done_at, prev_done, nstarts, w;
        bit got;
        w = 0;
        while (!req_ready && w < 50) begin step(); w++; end
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
        req_cmd   = 8'($urandom());
        req_addr  = 48'({$urandom(), $urandom()});
        req_wdata = {$urandom(), $urandom()};
        t = 0; att = -1; s_last = 0; done_at = -1; prev_done = -1; nstarts = 0; got = 1'b0;
        for (int k = 0; k < TIMEOUT + 400 && !got; k++) begin
            done = 1'b0; rd_data = '0;
            {crc_ca_error_slave, crc_data_error_slave, crc_data_error_master} = 3'b000;
            if (start) begin
                att++; nstarts++;
                chk("start_command", 64'(command), 64'(cmd));
                chk("start_address", 64'(address), 64'(addr));
                chk("start_wr_data", wr_data, wd);
                if (prev_done >= 0) chk("retry_gap", 64'(t), 64'(prev_done + GAP_CYCLES + 2));
                s_last  = t;
                done_at = (att == to_att || att > MAX_RETRY) ? -1 : t + 1 + int'($urandom_range(0, 5));
                if (spur) begin
                    done = 1'b1; rd_data = '1;
                    {crc_ca_error_slave, crc_data_error_slave, crc_data_error_master} = 3'b111;
                end
            end
            if (t == done_at) begin
                done = 1'b1; rd_data = rd;
                {crc_ca_error_slave, crc_data_error_slave, crc_data_error_master} = flags[3*att +: 3];
                prev_done = t;
            end
            if (rsp_valid) got = 1'b1;
            else begin step(); t++; end
        end
        done = 1'b0; rd_data = '0;
        {crc_ca_error_slave, crc_data_error_slave, crc_data_error_master} = 3'b000;
        if (!got) begin
            chk("rsp_wait_bound", 64'(0), 64'(1));
        end else begin
            if (e_st == 2'b10) chk("timeout_latency", 64'(t), 64'(s_last + 1 + TIMEOUT));
            else               chk("rsp_latency",     64'(t), 64'(prev_done + 2));
        end
        chk("rsp_status",  64'(rsp_status),  64'(e_st));
        chk("rsp_retries", 64'(rsp_retries), 64'(e_ret));
        chk("rsp_rdata",   rsp_rdata,        e_rd);
        chk("start_count", 64'(nstarts),     64'(e_ret) + 64'(1));
        chk("busy_resp",   64'(busy),        64'(1));
        chk("req_ready_resp", 64'(req_ready), 64'(0));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid",     64'(rsp_valid),   64'(1));
            chk("hold_status",    64'(rsp_status),  64'(e_st));
            chk("hold_rdata",     rsp_rdata,        e_rd);
            chk("hold_retries",   64'(rsp_retries), 64'(e_ret));
            chk("hold_req_ready", 64'(req_ready),   64'(0));
            chk("hold_address",   64'(address),     64'(addr));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_hs_valid",     64'(rsp_valid), 64'(0));
        chk("post_hs_req_ready", 64'(req_ready), 64'(1));
        chk("post_hs_busy",      64'(busy),      64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time %0t expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m_st;
        logic [3:0]  m_ret;
        logic [63:0] m_rd;
        logic [7:0]  rcmd;
        logic [11:0] rflags;
        int          rto;

        rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; rd_data = '0; done = 1'b0;
        crc_ca_error_slave = 1'b0; crc_data_error_slave = 1'b0; crc_data_error_master = 1'b0;

        tbl[0]  = '{8'hA5, 48'h0000_0000_1000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 12'h000, -1, 1'b0, 0, 2'b00, 4'd0, 64'h0};
        tbl[1]  = '{8'hFF, 48'h0000_0000_1000, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 12'h000, -1, 1'b0, 0, 2'b00, 4'd0, 64'hDEAD_BEEF_CAFE_F00D};
        tbl[2]  = '{8'hA5, 48'h0000_0000_2000, 64'h1111_2222_3333_4444, 64'h0, 12'h002, -1, 1'b0, 0, 2'b00, 4'd1, 64'h0};
        tbl[3]  = '{8'hFF, 48'h0000_0000_3000, 64'h0, 64'h5555_6666_7777_8888, 12'h249, -1, 1'b0, 0, 2'b01, 4'd3, 64'h0};
        tbl[4]  = '{8'hA5, 48'h0000_0000_4000, 64'h9999_AAAA_BBBB_CCCC, 64'h0, 12'h000, 0, 1'b0, 0, 2'b10, 4'd0, 64'h0};
        tbl[5]  = '{8'hA5, 48'hFFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 12'h249, -1, 1'b0, 0, 2'b00, 4'd0, 64'h0};
        tbl[6]  = '{8'h3C, 48'h1234_5678_9ABC, 64'h0F0F_0F0F_0F0F_0F0F, 64'hABCD, 12'h6DB, -1, 1'b0, 0, 2'b00, 4'd0, 64'h0};
        tbl[7]  = '{8'h3C, 48'h0000_0000_0040, 64'h2, 64'h3, 12'h024, -1, 1'b0, 0, 2'b00, 4'd2, 64'h0};
        tbl[8]  = '{8'hFF, 48'h0000_0000_5000, 64'h0, 64'h7, 12'h004, 1, 1'b0, 0, 2'b10, 4'd1, 64'h0};
        tbl[9]  = '{8'hFF, 48'h0000_0000_6000, 64'h0, 64'h0123_4567_89AB_CDEF, 12'h000, -1, 1'b1, 10, 2'b00, 4'd0, 64'h0123_4567_89AB_CDEF};
        tbl[10] = '{8'hFF, 48'h0000_0000_7000, 64'h0, 64'hFEDC_BA98_7654_3210, 12'h492, -1, 1'b0, 0, 2'b00, 4'd0, 64'hFEDC_BA98_7654_3210};
        tbl[11] = '{8'hFF, 48'h0000_0000_8000, 64'h0, 64'h0000_0000_CAFE_0001, 12'h049, -1, 1'b0, 2, 2'b00, 4'd3, 64'h0000_0000_CAFE_0001};

        step(); step(); step();
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();

        foreach (tbl[i])
            run_txn(tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].flags,
                    tbl[i].to_att, tbl[i].spur, tbl[i].hold, tbl[i].st, tbl[i].ret, tbl[i].rdo);

        // Reset while waiting on the core abandons the attempt silently.
        req_valid = 1'b1; req_cmd = 8'hA5; req_addr = 48'hABC; req_wdata = 64'h77;
        step();
        req_valid = 1'b0;
        chk("mid_start", 64'(start), 64'(1));
        step(); step();
        chk("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        step();
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        done = 1'b1; crc_ca_error_slave = 1'b1; rd_data = '1;
        step();
        done = 1'b0; crc_ca_error_slave = 1'b0; rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("after_reset_no_rsp",   64'(rsp_valid), 64'(0));
            chk("after_reset_no_start", 64'(start),     64'(0));
        end

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       rcmd = 8'hA5;
                1, 3:    rcmd = 8'hFF;
                default: rcmd = 8'($urandom());
            endcase
            rflags = 12'($urandom()) & 12'($urandom());
            rto    = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1;
            m_rd   = {$urandom(), $urandom()};
            model(rcmd, rflags, rto, m_rd, m_st, m_ret, m_rd);
            run_txn(rcmd, 48'({$urandom(), $urandom()}), {$urandom(), $urandom()},
                    (m_st == 2'b00 && rcmd == 8'hFF) ? m_rd : {$urandom(), $urandom()},
                    rflags, rto, 1'($urandom()), int'($urandom_range(0, 3)),
                    m_st, m_ret, m_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
